dense_layer_seq: RTL

Sequential, handshaked successor to the combinational dense layer. It accepts one Q-format input vector per transaction and computes y[i] = sat(round(Σj W[i][j]·x[j] + b[i])) for M neurons. It uses M parallel multiply-accumulate lanes iterated over N cycles. It sits between an upstream vector source and the next layer or activation stage, with valid/ready on both sides.

---
 rtl/dense_layer_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dense_layer_seq.sv
// Sequential dense layer: M parallel MAC lanes iterated over N input features,
// valid/ready on both sides. Optional ReLU output stage: DENSE_LAYER_SEQ_RELU_EN.
module dense_layer_seq #(
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 2*WIDTH + $clog2(N) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] weights  [M][N],
  input  logic signed [WIDTH-1:0] bias     [M],
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data  [N],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data [M],
  output logic                    out_sat
);

  localparam int JW = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) <<< (FRAC-1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [JW-1:0]             j_q;
  logic signed [WIDTH-1:0]   x_q   [N];
  logic signed [ACC_W-1:0]   acc_q [M];

  logic signed [2*WIDTH-1:0] prod  [M];
  logic signed [ACC_W-1:0]   rnd   [M];
  logic signed [WIDTH-1:0]   res   [M];
  logic [M-1:0]              clamp;
  logic                      last_mac;

  assign in_ready = (state_q == IDLE);
  assign last_mac = (j_q == JW'(N-1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)              state_d = MAC;
      MAC:     if (last_mac)              state_d = OUT;
      OUT:     if (out_valid && out_ready) state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Per-lane product, round-half-up, saturation and optional activation.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      prod[i]  = (2*WIDTH)'(weights[i][j_q]) * (2*WIDTH)'(x_q[j_q]);
      rnd[i]   = (acc_q[i] + HALF) >>> FRAC;
      res[i]   = rnd[i][WIDTH-1:0];
      clamp[i] = 1'b0;
      if (rnd[i] > SAT_MAX) begin
        res[i]   = SAT_MAX[WIDTH-1:0];
        clamp[i] = 1'b1;
      end else if (rnd[i] < SAT_MIN) begin
        res[i]   = SAT_MIN[WIDTH-1:0];
        clamp[i] = 1'b1;
      end
`ifdef DENSE_LAYER_SEQ_RELU_EN
      if (res[i][WIDTH-1]) res[i] = '0;
`endif
    end
  end

  // NOTE: the operand and accumulator arrays are reset too, so a reset in the
  // middle of a vector leaves no stale partial sums behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q       <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      for (int j = 0; j < N; j++) x_q[j] <= '0;
      for (int i = 0; i < M; i++) begin
        acc_q[i]    <= '0;
        out_data[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            j_q <= '0;
            for (int j = 0; j < N; j++) x_q[j] <= in_data[j];
            for (int i = 0; i < M; i++) acc_q[i] <= ACC_W'(bias[i]) <<< FRAC;
          end
        end
        MAC: begin
          for (int i = 0; i < M; i++) acc_q[i] <= acc_q[i] + ACC_W'(prod[i]);
          j_q <= last_mac ? '0 : j_q + JW'(1);
        end
        OUT: begin
          // First OUT cycle registers the result; later cycles wait for the sink.
          if (!out_valid) begin
            for (int i = 0; i < M; i++) out_data[i] <= res[i];
            out_sat   <= |clamp;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
